// File: rtl/cpu_pkg.sv
// Shared encodings for the 8-bit RISC CPU: opcodes, control states and fetch codes.
// Imported by the controller, instruction register and datapath.
package cpu_pkg;

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_LDR = 3'b001;
    localparam logic [2:0] OP_STR = 3'b010;
    localparam logic [2:0] OP_ADD = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [2:0] OP_JMP = 3'b101;
    localparam logic [2:0] OP_JZ  = 3'b110;
    localparam logic [2:0] OP_HLT = 3'b111;

    localparam logic [1:0] FETCH_HOLD = 2'b00;
    localparam logic [1:0] FETCH_INS  = 2'b01;
    localparam logic [1:0] FETCH_ADR  = 2'b10;

    typedef enum logic [2:0] {
        S_RST  = 3'd0,
        S_F1   = 3'd1,
        S_F2   = 3'd2,
        S_DEC  = 3'd3,
        S_MRD  = 3'd4,
        S_MWR  = 3'd5,
        S_HALT = 3'd6,
        S_ERR  = 3'd7
    } state_t;

    // Ops whose register write-back comes from the ALU rather than RAM.
    function automatic logic is_alu_op(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts un-acknowledged RAM wait cycles; expired is high during the last allowed un-acked cycle.
// Clear has priority over enable; the count only moves while enabled.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign expired = (cnt == CW'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/cpu_ctrl.sv
// Main control FSM of the 8-bit RISC CPU: fetches two-byte instructions, decodes them and
// drives PC, RAM, ALU and register-file strobes; counts retired instructions.
module cpu_ctrl
    import cpu_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int ICNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        ins,
    input  logic              zero,
    input  logic              mem_ack,
    input  logic              go,
    output logic [1:0]        fetch,
    output logic              pc_inc,
    output logic              pc_load,
    output logic              ram_rd,
    output logic              ram_wr,
    output logic              reg_wr,
    output logic              wb_sel,
    output logic              alu_op,
    output logic              halt,
    output logic              err,
    output logic [ICNT_W-1:0] icount
);

    state_t            state;
    state_t            state_nxt;
    logic              in_mem;
    logic              expired;
    logic              retire;
    logic [ICNT_W-1:0] icount_q;

    assign in_mem = (state == S_MRD) || (state == S_MWR);

    mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (!in_mem),
        .enable (in_mem && !mem_ack),
        .expired(expired)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_RST;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_RST: state_nxt = S_F1;
            S_F1:  state_nxt = S_F2;
            S_F2:  state_nxt = S_DEC;
            S_DEC: begin
                case (ins)
                    OP_HLT:                 state_nxt = S_HALT;
                    OP_STR:                 state_nxt = S_MWR;
                    OP_LDR, OP_ADD, OP_SUB: state_nxt = S_MRD;
                    default:                state_nxt = S_F1;
                endcase
            end
            S_MRD, S_MWR: begin
                // An ack in the final allowed cycle still completes the access.
                if (mem_ack) begin
                    state_nxt = S_F1;
                end else if (expired) begin
                    state_nxt = S_ERR;
                end
            end
            S_HALT: if (go) state_nxt = S_F1;
            S_ERR:  state_nxt = S_ERR;
            default: state_nxt = S_RST;
        endcase
    end

    always_comb begin
        fetch   = FETCH_HOLD;
        pc_inc  = 1'b0;
        pc_load = 1'b0;
        ram_rd  = 1'b0;
        ram_wr  = 1'b0;
        reg_wr  = 1'b0;
        wb_sel  = 1'b0;
        alu_op  = 1'b0;
        halt    = 1'b0;
        err     = 1'b0;
        case (state)
            S_F1: begin
                fetch  = FETCH_INS;
                pc_inc = 1'b1;
            end
            S_F2: begin
                fetch  = FETCH_ADR;
                pc_inc = 1'b1;
            end
            S_DEC: pc_load = (ins == OP_JMP) || ((ins == OP_JZ) && zero);
            S_MRD: begin
                ram_rd = 1'b1;
                if (mem_ack) begin
                    reg_wr = 1'b1;
                    wb_sel = is_alu_op(ins);
                    alu_op = (ins == OP_SUB);
                end
            end
            S_MWR:  ram_wr = 1'b1;
            S_HALT: halt = 1'b1;
            S_ERR: begin
                halt = 1'b1;
                err  = 1'b1;
            end
            default: ;
        endcase
    end

    // An instruction retires when control leaves it for the next fetch or for HALT.
    assign retire = ((state == S_DEC) && ((state_nxt == S_F1) || (state_nxt == S_HALT))) ||
                    (in_mem && (state_nxt == S_F1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            icount_q <= '0;
        end else if (retire) begin
            icount_q <= icount_q + ICNT_W'(1);
        end
    end

    assign icount = icount_q;

endmodule

// File: tb/tb_cpu_ctrl.sv
// Scoreboard bench for cpu_ctrl: instruction-level model expands each instruction into its
// expected per-cycle strobe pattern; a monitor compares every cycle against the queue.
module tb_cpu_ctrl;

    localparam int TMO = 16;

    localparam logic [2:0] NOP = 3'd0, LDR = 3'd1, STR = 3'd2, ADD = 3'd3;
    localparam logic [2:0] SUB = 3'd4, JMP = 3'd5, JZ = 3'd6, HLT = 3'd7;

    typedef struct packed {
        logic [1:0]  fetch;
        logic        pc_inc;
        logic        pc_load;
        logic        ram_rd;
        logic        ram_wr;
        logic        reg_wr;
        logic        wb_sel;
        logic        alu_op;
        logic        halt;
        logic        err;
        logic [15:0] icount;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  ins;
    logic        zero;
    logic        mem_ack;
    logic        go;
    logic [1:0]  fetch;
    logic        pc_inc, pc_load, ram_rd, ram_wr, reg_wr, wb_sel, alu_op, halt, err;
    logic [15:0] icount;

    obs_t        exp_q[$];
    string       tag_q[$];
    logic [15:0] m_icnt;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    cpu_ctrl #(.MEM_TIMEOUT(TMO), .ICNT_W(16)) dut (
        .clk(clk), .rst(rst), .ins(ins), .zero(zero), .mem_ack(mem_ack), .go(go),
        .fetch(fetch), .pc_inc(pc_inc), .pc_load(pc_load), .ram_rd(ram_rd), .ram_wr(ram_wr),
        .reg_wr(reg_wr), .wb_sel(wb_sel), .alu_op(alu_op), .halt(halt), .err(err),
        .icount(icount)
    );

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic obs_t mk(input logic [1:0] f, input logic pci, input logic pcl,
                                input logic rr, input logic rw, input logic rg,
                                input logic wb, input logic ao, input logic h, input logic e);
        obs_t o;
        o.fetch   = f;
        o.pc_inc  = pci;
        o.pc_load = pcl;
        o.ram_rd  = rr;
        o.ram_wr  = rw;
        o.reg_wr  = rg;
        o.wb_sel  = wb;
        o.alu_op  = ao;
        o.halt    = h;
        o.err     = e;
        o.icount  = m_icnt;
        return o;
    endfunction

    task automatic step(input logic [2:0] i_ins, input logic i_zero, input logic i_ack,
                        input logic i_go, input logic i_rst, input obs_t e, input string tag);
        @(negedge clk);
        ins     = i_ins;
        zero    = i_zero;
        mem_ack = i_ack;
        go      = i_go;
        rst     = i_rst;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic do_reset(input int n);
        m_icnt = '0;
        repeat (n) step(3'($urandom_range(0, 7)), rb(), rb(), rb(), 1'b0, mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0), "reset_low");
        step(NOP, 1'b0, rb(), rb(), 1'b1, mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0), "rst_state");
    endtask

    task automatic fetch_dec(input logic [2:0] op, input logic z);
        step(op, z, rb(), rb(), 1'b1, mk(2'b01, 1, 0, 0, 0, 0, 0, 0, 0, 0), "f1");
        step(op, z, rb(), rb(), 1'b1, mk(2'b10, 1, 0, 0, 0, 0, 0, 0, 0, 0), "f2");
        step(op, z, rb(), rb(), 1'b1,
             mk(2'b00, 0, (op == JMP) || (op == JZ && z), 0, 0, 0, 0, 0, 0, 0), "dec");
    endtask

    // Returns 1 when the instruction ended in the error state.
    task automatic do_instr(input logic [2:0] op, input logic z, input int wt, output bit to_err);
        logic wr;
        to_err = 0;
        fetch_dec(op, z);
        if (op == NOP || op == JMP || op == JZ) begin
            m_icnt = m_icnt + 16'd1;
        end else if (op == HLT) begin
            m_icnt = m_icnt + 16'd1;
            repeat ($urandom_range(0, 3))
                step(op, z, rb(), 1'b0, 1'b1, mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 0), "halt_wait");
            step(op, z, rb(), 1'b1, 1'b1, mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 0), "halt_go");
        end else begin
            wr = (op == STR);
            for (int k = 0; k < wt && k < TMO; k++)
                step(op, z, 1'b0, rb(), 1'b1, mk(2'b00, 0, 0, !wr, wr, 0, 0, 0, 0, 0), "mem_wait");
            if (wt >= TMO) begin
                to_err = 1;
            end else begin
                step(op, z, 1'b1, rb(), 1'b1,
                     mk(2'b00, 0, 0, !wr, wr, !wr, (op == ADD || op == SUB), (op == SUB), 0, 0),
                     "mem_ack");
                m_icnt = m_icnt + 16'd1;
            end
        end
    endtask

    task automatic run(input logic [2:0] op, input logic z, input int wt);
        bit e;
        do_instr(op, z, wt, e);
    endtask

    // Monitor: compares each cycle's outputs, sampled late in the low phase.
    initial begin
        obs_t  e;
        obs_t  a;
        string t;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                a = {fetch, pc_inc, pc_load, ram_rd, ram_wr, reg_wr, wb_sel, alu_op, halt, err, icount};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL %s at %0t: got %h expected %h", t, $time, a, e);
                end
            end
        end
    end

    initial begin
        bit to_err;
        int drain;
        rst = 1'b0; ins = NOP; zero = 1'b0; mem_ack = 1'b0; go = 1'b0;
        m_icnt = '0;

        do_reset(3);
        run(NOP, 0, 0);
        run(JZ, 1, 0);
        run(JZ, 0, 0);
        run(JMP, 0, 0);
        run(LDR, 0, 3);
        run(SUB, 0, 0);
        run(ADD, 1, 2);
        run(STR, 0, 2);
        run(HLT, 0, 0);
        run(LDR, 0, TMO - 1);

        for (int i = 0; i < 80; i++)
            run(3'($urandom_range(0, 7)), rb(),
                ($urandom_range(0, 9) == 0) ? TMO - 1 : int'($urandom_range(0, 5)));

        do_instr(STR, 0, TMO, to_err);
        if (to_err) begin
            repeat (6)
                step(3'($urandom_range(0, 7)), rb(), rb(), 1'b1, 1'b1,
                     mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 1), "err_sticky");
        end
        do_reset(2);
        run(NOP, 0, 0);

        // Reset during a RAM read must drop ram_rd before the next edge and retire nothing.
        fetch_dec(LDR, 0);
        repeat (2) step(LDR, 0, 1'b0, 1'b0, 1'b1, mk(2'b00, 0, 0, 1, 0, 0, 0, 0, 0, 0), "mid_wait");
        do_reset(1);
        run(ADD, 0, 1);
        run(HLT, 0, 0);
        run(NOP, 0, 0);

        drain = 0;
        while (exp_q.size() > 0 && drain < 20) begin
            @(negedge clk);
            drain++;
        end
        #5;
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
